// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller: rotates one anode per slot and shows clip number, elapsed seconds and mode letter.
// Optional `BLINK_EN` adds a 2 Hz blink of the record letter on digit 7.
module seg_scan_ctrl #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2,
    parameter int TICK_DIV     = 100000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clip_num,
    input  logic       record_or_play,
    input  logic       active,
    input  logic       start,
    output logic [6:0] cathode,
    output logic [7:0] anode,
    output logic [7:0] elapsed_bcd
);

    localparam int SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_CYCLES);
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);

    localparam logic [6:0] SEG_OFF    = 7'b1111111;
    localparam logic [6:0] SEG_CLIP_1 = 7'b1001111;
    localparam logic [6:0] SEG_CLIP_2 = 7'b0010010;
    localparam logic [6:0] SEG_REC    = 7'b1111010;
    localparam logic [6:0] SEG_PLAY   = 7'b0011000;

    logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [2:0]        slot_idx_q, slot_idx_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [7:0]        elapsed_q, elapsed_d;
    logic [7:0]        anode_q, anode_d;
    logic [6:0]        cathode_q, cathode_d;
    logic [6:0]        glyph;
    logic              digit7_blank;

    function automatic logic [6:0] seg7(input logic [3:0] val);
        case (val)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = SEG_OFF;
        endcase
    endfunction

`ifdef BLINK_EN
    localparam int BLINK_DIV = (TICK_DIV / 4 > 1) ? TICK_DIV / 4 : 1;
    localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_off_q, blink_off_d;

    // Free-running half-period counter; start re-aligns the phase to "on".
    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_off_d = blink_off_q;
        if (start) begin
            blink_cnt_d = '0;
            blink_off_d = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_off_d = ~blink_off_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
        end
    end

    assign digit7_blank = active & record_or_play & blink_off_q;
`else
    assign digit7_blank = 1'b0;
`endif

    always_comb begin
        slot_cnt_d = slot_cnt_q + 1'b1;
        slot_idx_d = slot_idx_q;
        if (slot_cnt_q == SLOT_LAST) begin
            slot_cnt_d = '0;
            slot_idx_d = slot_idx_q + 3'd1;
        end
    end

    always_comb begin
        glyph = SEG_OFF;
        case (slot_idx_q)
            3'd0:    glyph = clip_num ? SEG_CLIP_2 : SEG_CLIP_1;
            3'd1:    glyph = seg7(elapsed_q[3:0]);
            3'd2:    glyph = seg7(elapsed_q[7:4]);
            3'd7:    glyph = digit7_blank ? SEG_OFF : (record_or_play ? SEG_REC : SEG_PLAY);
            default: glyph = SEG_OFF;
        endcase
    end

    // Leading cycles of every slot keep all anodes dark so the previous digit does not ghost.
    always_comb begin
        anode_d   = 8'h00;
        cathode_d = SEG_OFF;
        if (slot_cnt_q >= BLANK_LAST) begin
            anode_d   = 8'h01 << slot_idx_q;
            cathode_d = glyph;
        end
    end

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        elapsed_d  = elapsed_q;
        if (start) begin
            tick_cnt_d = '0;
            elapsed_d  = 8'h00;
        end else if (active) begin
            if (tick_cnt_q == TICK_LAST) begin
                tick_cnt_d = '0;
                // Saturate at 99 seconds rather than wrapping back to 00.
                if (elapsed_q != 8'h99) begin
                    if (elapsed_q[3:0] == 4'd9) begin
                        elapsed_d = {elapsed_q[7:4] + 4'd1, 4'd0};
                    end else begin
                        elapsed_d = {elapsed_q[7:4], elapsed_q[3:0] + 4'd1};
                    end
                end
            end else begin
                tick_cnt_d = tick_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_cnt_q <= '0;
            slot_idx_q <= 3'd0;
            tick_cnt_q <= '0;
            elapsed_q  <= 8'h00;
            anode_q    <= 8'h00;
            cathode_q  <= SEG_OFF;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            slot_idx_q <= slot_idx_d;
            tick_cnt_q <= tick_cnt_d;
            elapsed_q  <= elapsed_d;
            anode_q    <= anode_d;
            cathode_q  <= cathode_d;
        end
    end

    assign anode       = anode_q;
    assign cathode     = cathode_q;
    assign elapsed_bcd = elapsed_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with a short refresh slot and a ten-cycle seconds tick.
module tb_seg_scan_ctrl;
    localparam int REFRESH_DIV  = 4;
    localparam int BLANK_CYCLES = 1;
    localparam int TICK_DIV     = 10;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_R     = 7'b1111010;
    localparam logic [6:0] SEG_P     = 7'b0011000;

    logic       clock = 1'b0;
    logic       reset;
    logic       clip_num;
    logic       record_or_play;
    logic       active;
    logic       start;
    logic [6:0] cathode;
    logic [7:0] anode;
    logic [7:0] elapsed_bcd;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       clip;
        logic       rop;
        logic [7:0] exp_anode;
        logic [6:0] exp_cathode;
    } vec_t;

    vec_t vecs [12];

    seg_scan_ctrl #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES),
        .TICK_DIV    (TICK_DIV)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .clip_num      (clip_num),
        .record_or_play(record_or_play),
        .active        (active),
        .start         (start),
        .cathode       (cathode),
        .anode         (anode),
        .elapsed_bcd   (elapsed_bcd)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exhausted");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check7(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Waits for the start of a fresh slot showing the target anode.
    task automatic wait_fresh(input logic [7:0] target, input string name);
        int n = 0;
        while (anode === target && n < 40) begin
            step();
            n++;
        end
        while (anode !== target && n < 80) begin
            step();
            n++;
        end
        checks++;
        if (anode !== target) begin
            failures++;
            $display("FAIL %s: anode %h never reached %h within %0d cycles", name, anode, target, n);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    function automatic logic [6:0] idle_glyph(input int idx);
        case (idx)
            0:       idle_glyph = SEG_1;
            1, 2:    idle_glyph = SEG_0;
            7:       idle_glyph = SEG_R;
            default: idle_glyph = SEG_BLANK;
        endcase
    endfunction

    initial begin
        logic [7:0] prev;
        logic [7:0] exp_an;
        logic [6:0] exp_cat;
        int         drops;
        int         n;

        reset          = 1'b1;
        clip_num       = 1'b0;
        record_or_play = 1'b1;
        active         = 1'b0;
        start          = 1'b0;
        step_n(3);
        check8("reset_anode", anode, 8'h00);
        check7("reset_cathode", cathode, SEG_BLANK);
        check8("reset_elapsed", elapsed_bcd, 8'h00);
        reset = 1'b0;

        // Edges 1..12 after reset release: blank, then three lit cycles per slot.
        vecs[0]  = '{1'b0, 1'b1, 8'h00, SEG_BLANK};
        vecs[1]  = '{1'b0, 1'b1, 8'h01, SEG_1};
        vecs[2]  = '{1'b0, 1'b1, 8'h01, SEG_1};
        vecs[3]  = '{1'b0, 1'b1, 8'h01, SEG_1};
        vecs[4]  = '{1'b0, 1'b1, 8'h00, SEG_BLANK};
        vecs[5]  = '{1'b0, 1'b1, 8'h02, SEG_0};
        vecs[6]  = '{1'b0, 1'b1, 8'h02, SEG_0};
        vecs[7]  = '{1'b0, 1'b1, 8'h02, SEG_0};
        vecs[8]  = '{1'b0, 1'b1, 8'h00, SEG_BLANK};
        vecs[9]  = '{1'b0, 1'b1, 8'h04, SEG_0};
        vecs[10] = '{1'b0, 1'b1, 8'h04, SEG_0};
        vecs[11] = '{1'b0, 1'b1, 8'h04, SEG_0};
        for (int i = 0; i < 12; i++) begin
            clip_num       = vecs[i].clip;
            record_or_play = vecs[i].rop;
            step();
            check8($sformatf("scan_anode[%0d]", i), anode, vecs[i].exp_anode);
            check7($sformatf("scan_cathode[%0d]", i), cathode, vecs[i].exp_cathode);
        end

        // Rest of the first frame plus the wrap back to digit 0.
        for (int k = 13; k <= 34; k++) begin
            step();
            n = k - 1;
            if ((n % 4) < BLANK_CYCLES) begin
                exp_an  = 8'h00;
                exp_cat = SEG_BLANK;
            end else begin
                exp_an  = 8'(1 << ((n / 4) % 8));
                exp_cat = idle_glyph((n / 4) % 8);
            end
            check8($sformatf("frame_anode[%0d]", k), anode, exp_an);
            check7($sformatf("frame_cathode[%0d]", k), cathode, exp_cat);
        end

        wait_fresh(8'h80, "wait_rec");
        check7("mode_rec", cathode, SEG_R);
        record_or_play = 1'b0;
        wait_fresh(8'h80, "wait_play");
        check7("mode_play", cathode, SEG_P);
        clip_num = 1'b1;
        wait_fresh(8'h01, "wait_clip2");
        check7("clip_2", cathode, SEG_2);
        clip_num = 1'b0;

        pulse_start();
        check8("timer_cleared", elapsed_bcd, 8'h00);
        active = 1'b1;
        step_n(120);
        active = 1'b0;
        check8("timer_12", elapsed_bcd, 8'h12);
        wait_fresh(8'h02, "wait_ones");
        check7("ones_digit", cathode, SEG_2);
        wait_fresh(8'h04, "wait_tens");
        check7("tens_digit", cathode, SEG_1);
        step_n(50);
        check8("timer_hold", elapsed_bcd, 8'h12);

        pulse_start();
        active = 1'b1;
        step_n(90);
        check8("timer_09", elapsed_bcd, 8'h09);
        step_n(10);
        check8("timer_carry_10", elapsed_bcd, 8'h10);
        drops = 0;
        for (int i = 0; i < 1000; i++) begin
            prev = elapsed_bcd;
            step();
            if (elapsed_bcd < prev) drops++;
        end
        checks++;
        if (drops != 0) begin
            failures++;
            $display("FAIL timer_monotonic: got %0d drops expected 0", drops);
        end
        check8("timer_saturate", elapsed_bcd, 8'h99);

        active = 1'b0;
        pulse_start();
        active = 1'b1;
        step_n(10);
        check8("collide_pre", elapsed_bcd, 8'h01);
        step_n(9);
        start = 1'b1;
        step();
        start = 1'b0;
        check8("collide_tick9", elapsed_bcd, 8'h00);
        step_n(9);
        check8("collide_tick9_cnt", elapsed_bcd, 8'h00);
        step();
        check8("collide_tick9_next", elapsed_bcd, 8'h01);
        step_n(5);
        start = 1'b1;
        step();
        start = 1'b0;
        check8("collide_tick5", elapsed_bcd, 8'h00);
        step_n(9);
        check8("collide_tick5_cnt", elapsed_bcd, 8'h00);
        step();
        check8("collide_tick5_next", elapsed_bcd, 8'h01);

        wait_fresh(8'h10, "wait_slot4");
        step();
        reset = 1'b1;
        step();
        check8("midreset_anode", anode, 8'h00);
        check7("midreset_cathode", cathode, SEG_BLANK);
        check8("midreset_elapsed", elapsed_bcd, 8'h00);
        reset  = 1'b0;
        active = 1'b0;
        step();
        check8("resume_blank", anode, 8'h00);
        step();
        check8("resume_anode", anode, 8'h01);
        check7("resume_cathode", cathode, SEG_1);

`ifdef BLINK_EN
        begin
            int lit  = 0;
            int dark = 0;
            record_or_play = 1'b1;
            active         = 1'b1;
            for (int i = 0; i < 96; i++) begin
                step();
                if (anode === 8'h80 && cathode === SEG_R) lit++;
                if (anode === 8'h80 && cathode === SEG_BLANK) dark++;
            end
            active = 1'b0;
            checks++;
            if (lit == 0) begin
                failures++;
                $display("FAIL blink_lit: got %0d lit cycles expected >0", lit);
            end
            checks++;
            if (dark == 0) begin
                failures++;
                $display("FAIL blink_dark: got %0d dark cycles expected >0", dark);
            end
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 8-digit seven-segment display on the clip recorder board. It replaces the static two-digit driver with a sequencer that rotates one anode at a time and drives the shared active-low cathode bus. The display shows the clip number on digit 0, elapsed seconds on digits 2:1, and the record/play mode letter on digit 7. An internal seconds timer runs while a record or playback operation is active.

Parameters:
REFRESH_DIV, 100000, clock cycles per digit slot; legal range ≥ 2.
BLANK_CYCLES, 2, leading cycles of each slot with all anodes off (anti-ghosting); legal range 1 to REFRESH_DIV-1.
TICK_DIV, 100000000, clock cycles per elapsed-seconds increment.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
clip_num  in  1  0 = clip 1, 1 = clip 2
record_or_play  in  1  1 = record, 0 = play
active  in  1  record/playback in progress; timer runs while high
start  in  1  single-cycle pulse; clears the elapsed timer
cathode  out  7  segments a..g on bits 6..0, active-low
anode  out  8  digit enables, active-high, at most one bit set
elapsed_bcd  out  8  elapsed seconds, tens in [7:4], ones in [3:0]

Behaviour:
- Clocking and reset: one clock. All state is updated on posedge clock. Reset is synchronous, active-high, and overrides all other inputs.
- Reset values: anode = 8'h00, cathode = 7'b1111111, elapsed_bcd = 8'h00. slot_cnt, slot_idx and tick_cnt are all 0.
- Slot counter:
  - slot_cnt counts 0..REFRESH_DIV-1.
  - At terminal count it wraps to 0 and slot_idx increments mod 8 (7 → 0).
- Output registers:
  - anode and cathode are registered from the slot_cnt and slot_idx values present before the edge.
  - If slot_cnt < BLANK_CYCLES: anode = 0, cathode = 7'b1111111.
  - Otherwise: anode = 1 << slot_idx, cathode = glyph(slot_idx).
- Glyphs (active-low a..g):
  - Digit 0: clip number. 7'b1001111 ("1") when clip_num = 0; 7'b0010010 ("2") when clip_num = 1.
  - Digit 1: ones of elapsed_bcd. Digit 2: tens of elapsed_bcd.
  - Digit 7: 7'b1111010 ("r") when record_or_play = 1; 7'b0011000 ("P") when 0.
  - Digits 3..6: blank, 7'b1111111, with the anode still asserted.
  - BCD digit codes 0..9: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
- Input timing: clip_num and record_or_play are sampled every cycle. A change is visible on the next output update of the affected digit.
- Elapsed timer:
  - start = 1: tick_cnt ← 0 and elapsed_bcd ← 00. start has priority over a tick in the same cycle.
  - Else if active = 1: tick_cnt increments. At TICK_DIV-1 it wraps to 0 and elapsed_bcd increments in BCD (ones 9 → 0 carries into tens).
  - The timer saturates at 99; no wrap.
  - active = 0: tick_cnt and elapsed_bcd hold.
- Reset mid-slot: the outputs go blank on the next cycle and scanning restarts at slot 0, slot_cnt 0.

Optional Feature:
BLINK_EN
- Defined: adds a free-running blink counter of TICK_DIV/4 cycles. Its toggling phase gives 2 Hz.
  - While active = 1 and record_or_play = 1, digit 7 is blanked during the off phase.
  - The blink counter and phase reset to 0 (phase on) on reset or start.
- Not defined: digit 7 is always lit. No blink counter logic exists.

Test Plan:
1. Reset scan, with REFRESH_DIV = 4, BLANK_CYCLES = 1, TICK_DIV = 10. Release reset with clip_num = 0 → the first output update is blank (anode 00, cathode 1111111). The next update gives anode 01 with cathode 1001111 for 3 cycles, then one blank cycle, then anode 02 with cathode 0000001. Anode cycles 01 → 02 → … → 80 → 01 every 32 cycles.
2. Mode letter. With record_or_play = 1, the anode 80 slot shows cathode 1111010. Switch to 0 → the next anode 80 slot shows 0011000.
3. Timer. Pulse start, then hold active = 1 for 120 cycles → elapsed_bcd = 8'h12. The anode 02 slot shows 0010010 and the anode 04 slot shows 1001111. Drop active → the value holds at 12.
4. Carry and saturation. Hold active for 1000+ cycles → elapsed_bcd passes 09 → 10 and stops at 99, never 00.
5. Start versus tick collision. Assert start on the cycle tick_cnt = 9 → elapsed_bcd = 00 and tick_cnt = 0.
6. Mid-operation reset. Assert reset during the anode 10 slot → on the next cycle anode = 00 and elapsed_bcd = 00. Scanning resumes at slot 0. With BLINK_EN defined, active = 1 and record_or_play = 1: digit 7 alternates between lit and blank every TICK_DIV/4 cycles.
